demux_stream_router: RTL and testbench

- Upstream steering stage for the 1-bit demux datapath.
- Accepts a valid/ready input stream and routes each word to one of two registered output channels, y0 or y1.
- Destination comes from a per-word dest bit (directed mode) or from an internal alternating pointer (round-robin mode).
- Each output has a one-entry holding register, so a stalled sink never corrupts the other channel.

---
 rtl/demux_stream_router.sv | 137 +++++++++++++
 tb/tb_demux_stream_router.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/demux_stream_router.sv
// Routes a valid/ready stream to one of two one-entry output slots, y0 or y1.
// Optional per-channel saturating handshake counters are enabled with `define DEMUX_STATS_EN.
module demux_stream_router #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic             x_dest,
  input  logic             x_valid,
  output logic             x_ready,
  input  logic             mode,
  output logic [WIDTH-1:0] y0,
  output logic             y0_valid,
  input  logic             y0_ready,
  output logic [WIDTH-1:0] y1,
  output logic             y1_valid,
  input  logic             y1_ready,
`ifdef DEMUX_STATS_EN
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
`endif
  output logic             sel
);

  // state | meaning
  // EMPTY | slot holds no word, yN_valid = 0
  // FULL  | slot holds a word for the sink, yN_valid = 1
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_t;

  if (CNT_W < 1) begin : g_cnt_w_chk
    $error("CNT_W must be at least 1");
  end

  slot_t st0;
  slot_t st1;
  logic  mode_q;
  logic  rr_ptr;
  logic  eff_ptr;
  logic  acc;
  logic  acc0;
  logic  acc1;
  logic  drain0;
  logic  drain1;

  // On the cycle round-robin is first entered the pointer reads as 0,
  // so the first word after the switch always lands on y0.
  assign eff_ptr  = mode_q ? rr_ptr : 1'b0;
  assign sel      = mode ? eff_ptr : x_dest;

  assign y0_valid = (st0 == FULL);
  assign y1_valid = (st1 == FULL);
  assign drain0   = y0_valid & y0_ready;
  assign drain1   = y1_valid & y1_ready;

  assign x_ready  = sel ? (~y1_valid | y1_ready) : (~y0_valid | y0_ready);
  assign acc      = x_valid & x_ready;
  assign acc0     = acc & ~sel;
  assign acc1     = acc & sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= 1'b0;
      rr_ptr <= 1'b0;
    end else begin
      mode_q <= mode;
      if (mode) begin
        rr_ptr <= eff_ptr ^ acc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st0 <= EMPTY;
      st1 <= EMPTY;
      y0  <= '0;
      y1  <= '0;
    end else begin
      case (st0)
        EMPTY: begin
          if (acc0) begin
            st0 <= FULL;
            y0  <= x;
          end
        end
        FULL: begin
          if (acc0) begin
            y0 <= x;
          end else if (drain0) begin
            st0 <= EMPTY;
          end
        end
        default: st0 <= EMPTY;
      endcase

      case (st1)
        EMPTY: begin
          if (acc1) begin
            st1 <= FULL;
            y1  <= x;
          end
        end
        FULL: begin
          if (acc1) begin
            y1 <= x;
          end else if (drain1) begin
            st1 <= EMPTY;
          end
        end
        default: st1 <= EMPTY;
      endcase
    end
  end

`ifdef DEMUX_STATS_EN
  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (drain0 && (cnt0 != {CNT_W{1'b1}})) begin
        cnt0 <= cnt0 + 1'b1;
      end
      if (drain1 && (cnt1 != {CNT_W{1'b1}})) begin
        cnt1 <= cnt1 + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_demux_stream_router.sv
// Directed testbench for demux_stream_router: reset, directed routing, stall isolation,
// round-robin alternation and stall, mode switching, mid-transfer reset and optional counters.
module tb_demux_stream_router;
  localparam int WIDTH = 8;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] x;
  logic             x_dest;
  logic             x_valid;
  logic             x_ready;
  logic             mode;
  logic [WIDTH-1:0] y0;
  logic             y0_valid;
  logic             y0_ready;
  logic [WIDTH-1:0] y1;
  logic             y1_valid;
  logic             y1_ready;
  logic             sel;
`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  demux_stream_router #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .x(x),
    .x_dest(x_dest),
    .x_valid(x_valid),
    .x_ready(x_ready),
    .mode(mode),
    .y0(y0),
    .y0_valid(y0_valid),
    .y0_ready(y0_ready),
    .y1(y1),
    .y1_valid(y1_valid),
    .y1_ready(y1_ready),
`ifdef DEMUX_STATS_EN
    .cnt0(cnt0),
    .cnt1(cnt1),
`endif
    .sel(sel)
  );

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; x = 8'h55; x_dest = 1'b0; x_valid = 1'b1; mode = 1'b0;
    y0_ready = 1'b1; y1_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++; if (y0_valid !== 1'b0) begin bad++; $display("FAIL rst_y0_valid got=%b exp=0", y0_valid); end
    total++; if (y1_valid !== 1'b0) begin bad++; $display("FAIL rst_y1_valid got=%b exp=0", y1_valid); end
    total++; if (y0 !== 8'h00) begin bad++; $display("FAIL rst_y0 got=%h exp=00", y0); end
    total++; if (y1 !== 8'h00) begin bad++; $display("FAIL rst_y1 got=%h exp=00", y1); end
    total++; if (x_ready !== 1'b1) begin bad++; $display("FAIL rst_x_ready got=%b exp=1", x_ready); end
    rst = 1'b0; x_valid = 1'b0;
  endtask

  task automatic test_directed();
    @(negedge clk);
    mode = 1'b0; y0_ready = 1'b1; y1_ready = 1'b1;
    x = 8'h11; x_dest = 1'b0; x_valid = 1'b1;
    #1;
    total++; if (x_ready !== 1'b1) begin bad++; $display("FAIL dir_ready_11 got=%b exp=1", x_ready); end
    @(negedge clk);
    total++; if ({y0_valid, y0} !== {1'b1, 8'h11}) begin bad++; $display("FAIL dir_y0_11 got=%b/%h exp=1/11", y0_valid, y0); end
    x = 8'h22; x_dest = 1'b1;
    #1;
    total++; if (x_ready !== 1'b1) begin bad++; $display("FAIL dir_ready_22 got=%b exp=1", x_ready); end
    @(negedge clk);
    total++; if ({y1_valid, y1} !== {1'b1, 8'h22}) begin bad++; $display("FAIL dir_y1_22 got=%b/%h exp=1/22", y1_valid, y1); end
    total++; if (y0_valid !== 1'b0) begin bad++; $display("FAIL dir_y0_drained got=%b exp=0", y0_valid); end
    x = 8'h33; x_dest = 1'b0;
    @(negedge clk);
    total++; if ({y0_valid, y0} !== {1'b1, 8'h33}) begin bad++; $display("FAIL dir_y0_33 got=%b/%h exp=1/33", y0_valid, y0); end
    total++; if (y1_valid !== 1'b0) begin bad++; $display("FAIL dir_y1_drained got=%b exp=0", y1_valid); end
    x_valid = 1'b0;
    @(negedge clk);
    total++; if (y0_valid !== 1'b0) begin bad++; $display("FAIL dir_y0_idle got=%b exp=0", y0_valid); end
  endtask

  task automatic test_stall_isolation();
    @(negedge clk);
    mode = 1'b0; y0_ready = 1'b0; y1_ready = 1'b1;
    x = 8'hA0; x_dest = 1'b0; x_valid = 1'b1;
    @(negedge clk);
    total++; if ({y0_valid, y0} !== {1'b1, 8'hA0}) begin bad++; $display("FAIL iso_y0_a0 got=%b/%h exp=1/a0", y0_valid, y0); end
    x = 8'hA1; x_dest = 1'b0;
    #1;
    total++; if (x_ready !== 1'b0) begin bad++; $display("FAIL iso_ready_a1 got=%b exp=0", x_ready); end
    @(negedge clk);
    total++; if ({y0_valid, y0} !== {1'b1, 8'hA0}) begin bad++; $display("FAIL iso_hold_a0 got=%b/%h exp=1/a0", y0_valid, y0); end
    x = 8'hB0; x_dest = 1'b1;
    #1;
    total++; if (x_ready !== 1'b1) begin bad++; $display("FAIL iso_ready_b0 got=%b exp=1", x_ready); end
    @(negedge clk);
    total++; if ({y1_valid, y1} !== {1'b1, 8'hB0}) begin bad++; $display("FAIL iso_y1_b0 got=%b/%h exp=1/b0", y1_valid, y1); end
    total++; if (y0 !== 8'hA0) begin bad++; $display("FAIL iso_y0_still_a0 got=%h exp=a0", y0); end
    x = 8'hA1; x_dest = 1'b0; y0_ready = 1'b1;
    #1;
    total++; if (x_ready !== 1'b1) begin bad++; $display("FAIL iso_ready_release got=%b exp=1", x_ready); end
    @(negedge clk);
    total++; if ({y0_valid, y0} !== {1'b1, 8'hA1}) begin bad++; $display("FAIL iso_y0_a1 got=%b/%h exp=1/a1", y0_valid, y0); end
    total++; if (y1_valid !== 1'b0) begin bad++; $display("FAIL iso_y1_drained got=%b exp=0", y1_valid); end
    x_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    @(negedge clk);
    mode = 1'b1; y0_ready = 1'b1; y1_ready = 1'b1;
    x = 8'h01; x_dest = 1'b1; x_valid = 1'b1;
    #1;
    total++; if (sel !== 1'b0) begin bad++; $display("FAIL rr_sel_first got=%b exp=0", sel); end
    @(negedge clk);
    total++; if ({y0_valid, y0} !== {1'b1, 8'h01}) begin bad++; $display("FAIL rr_y0_01 got=%b/%h exp=1/01", y0_valid, y0); end
    x = 8'h02;
    #1;
    total++; if (sel !== 1'b1) begin bad++; $display("FAIL rr_sel_02 got=%b exp=1", sel); end
    @(negedge clk);
    total++; if ({y1_valid, y1} !== {1'b1, 8'h02}) begin bad++; $display("FAIL rr_y1_02 got=%b/%h exp=1/02", y1_valid, y1); end
    x = 8'h03; x_dest = 1'b0;
    @(negedge clk);
    total++; if ({y0_valid, y0} !== {1'b1, 8'h03}) begin bad++; $display("FAIL rr_y0_03 got=%b/%h exp=1/03", y0_valid, y0); end
    x = 8'h04; x_dest = 1'b0;
    @(negedge clk);
    total++; if ({y1_valid, y1} !== {1'b1, 8'h04}) begin bad++; $display("FAIL rr_y1_04 got=%b/%h exp=1/04", y1_valid, y1); end
    total++; if (y0_valid !== 1'b0) begin bad++; $display("FAIL rr_y0_drained got=%b exp=0", y0_valid); end
    x_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rr_stall_and_switch();
    @(negedge clk);
    mode = 1'b1; y0_ready = 1'b1; y1_ready = 1'b1;
    x = 8'h01; x_dest = 1'b1; x_valid = 1'b1;
    @(negedge clk);
    x = 8'h02; y1_ready = 1'b0;
    @(negedge clk);
    total++; if ({y1_valid, y1} !== {1'b1, 8'h02}) begin bad++; $display("FAIL rrs_y1_02 got=%b/%h exp=1/02", y1_valid, y1); end
    x = 8'h03;
    @(negedge clk);
    total++; if ({y0_valid, y0} !== {1'b1, 8'h03}) begin bad++; $display("FAIL rrs_y0_03 got=%b/%h exp=1/03", y0_valid, y0); end
    x = 8'h04;
    #1;
    total++; if ({sel, x_ready} !== 2'b10) begin bad++; $display("FAIL rrs_stall_04 got=sel%b/rdy%b exp=sel1/rdy0", sel, x_ready); end
    @(negedge clk);
    total++; if ({sel, x_ready, y0_valid} !== 3'b100) begin bad++; $display("FAIL rrs_no_skip got=sel%b/rdy%b/v0%b exp=1/0/0", sel, x_ready, y0_valid); end
    total++; if ({y1_valid, y1} !== {1'b1, 8'h02}) begin bad++; $display("FAIL rrs_hold_02 got=%b/%h exp=1/02", y1_valid, y1); end
    y1_ready = 1'b1;
    #1;
    total++; if (x_ready !== 1'b1) begin bad++; $display("FAIL rrs_release got=%b exp=1", x_ready); end
    @(negedge clk);
    total++; if ({y1_valid, y1} !== {1'b1, 8'h04}) begin bad++; $display("FAIL rrs_y1_04 got=%b/%h exp=1/04", y1_valid, y1); end
    x = 8'h05;
    @(negedge clk);
    total++; if ({y0_valid, y0} !== {1'b1, 8'h05}) begin bad++; $display("FAIL rrs_y0_05 got=%b/%h exp=1/05", y0_valid, y0); end
    x_valid = 1'b0; mode = 1'b0;
    @(negedge clk);
    mode = 1'b1; x = 8'h06; x_dest = 1'b1; x_valid = 1'b1;
    #1;
    total++; if (sel !== 1'b0) begin bad++; $display("FAIL sw_sel got=%b exp=0", sel); end
    @(negedge clk);
    total++; if ({y0_valid, y0, y1_valid} !== {1'b1, 8'h06, 1'b0}) begin bad++; $display("FAIL sw_y0_06 got=%b/%h/%b exp=1/06/0", y0_valid, y0, y1_valid); end
    x_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    mode = 1'b0; y0_ready = 1'b0; y1_ready = 1'b0;
    x = 8'hC3; x_dest = 1'b1; x_valid = 1'b1;
    @(negedge clk);
    total++; if ({y1_valid, y1} !== {1'b1, 8'hC3}) begin bad++; $display("FAIL mid_y1_c3 got=%b/%h exp=1/c3", y1_valid, y1); end
    rst = 1'b1;
    @(negedge clk);
    total++; if ({y1_valid, y1, y0_valid} !== {1'b0, 8'h00, 1'b0}) begin bad++; $display("FAIL mid_rst_drop got=%b/%h/%b exp=0/00/0", y1_valid, y1, y0_valid); end
    rst = 1'b0; x_valid = 1'b0; y0_ready = 1'b1; y1_ready = 1'b1;
    @(negedge clk);
  endtask

`ifdef DEMUX_STATS_EN
  task automatic test_stats();
    @(negedge clk);
    rst = 1'b1; x_valid = 1'b0; mode = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    total++; if ({cnt0, cnt1} !== 4'b0000) begin bad++; $display("FAIL st_rst got=%0d/%0d exp=0/0", cnt0, cnt1); end
    y0_ready = 1'b1; y1_ready = 1'b1; x_dest = 1'b0; x_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      x = 8'(8'h40 + i);
      @(negedge clk);
    end
    x_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (cnt0 !== 2'd3) begin bad++; $display("FAIL st_cnt0_sat got=%0d exp=3", cnt0); end
    total++; if (cnt1 !== 2'd0) begin bad++; $display("FAIL st_cnt1_zero got=%0d exp=0", cnt1); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if ({cnt0, cnt1} !== 4'b0000) begin bad++; $display("FAIL st_clear got=%0d/%0d exp=0/0", cnt0, cnt1); end
  endtask
`endif

  initial begin
    rst = 1'b1; x = '0; x_dest = 1'b0; x_valid = 1'b0; mode = 1'b0;
    y0_ready = 1'b1; y1_ready = 1'b1;
    test_reset();
    test_directed();
    test_stall_isolation();
    test_round_robin();
    test_rr_stall_and_switch();
    test_mid_reset();
`ifdef DEMUX_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
